svm_pipeline_ctrl: RTL

SVM_PIPELINE_CTRL -- requirements
Module: svm_pipeline_ctrl

---
 rtl/svm_pipeline_ctrl.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/svm_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// svm_pipeline_ctrl
//
// Sequences one SVM kernel job through a NUM_FEAT-stage inner-product pipeline.
// A job is accepted with a test vector, and N support vectors are then streamed
// from an external SV memory. Each SV element is skewed by one cycle per stage,
// so that stage k sees its element one cycle after stage k-1. Once the last SV
// has left the final stage, the final accumulator value is captured and
// presented on a valid/ready result port.
//
// Optional feature (macro SVM_CTRL_PERF_CNT_EN):
//   When defined, adds perf_jobs (completed result handshakes) and perf_busy
//   (busy cycles, counting the accept cycle). Both are free-running and wrap.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   cfg_num_sv     support vectors per job, clamped to [2, MAX_SV] at accept
//   req_*          job request handshake and test vector
//   sv_rd_en/addr  SV memory read port (1-cycle read latency)
//   sv_rdata       SV memory read data, element k at [k*DATA_SIZE +: DATA_SIZE]
//   curr_vector    latched test vector for stage 0
//   accum_seed     accumulator input of stage 0 (always 0)
//   sv_lane        per-stage SV element, skewed by stage index
//   start_inner    per-stage pulse on the first SV of a job
//   last_inner     per-stage pulse on the last SV of a job
//   accum_final    accumulator output of the last stage
//   res_*          result handshake and captured result
//   busy           high in every state except IDLE
//   perf_jobs/busy performance counters (SVM_CTRL_PERF_CNT_EN only)
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | req_ready high, waiting for a job
// FETCH  | issuing SV reads, address 0..N-1, one per cycle
// WAIT   | draining the stage skew, NUM_FEAT cycles
// RESULT | res_valid high, holding res_data until res_ready
// -----------------------------------------------------------------------------
module svm_pipeline_ctrl #(
  parameter int DATA_SIZE  = 32,
  parameter int ACCUM_SIZE = 64,
  parameter int NUM_FEAT   = 2,
  parameter int MAX_SV     = 16,
  localparam int AW        = $clog2(MAX_SV)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [AW:0]                   cfg_num_sv,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [NUM_FEAT*DATA_SIZE-1:0] req_vector,
  output logic                          sv_rd_en,
  output logic [AW-1:0]                 sv_addr,
  input  logic [NUM_FEAT*DATA_SIZE-1:0] sv_rdata,
  output logic [NUM_FEAT*DATA_SIZE-1:0] curr_vector,
  output logic [ACCUM_SIZE-1:0]         accum_seed,
  output logic [NUM_FEAT*DATA_SIZE-1:0] sv_lane,
  output logic [NUM_FEAT-1:0]           start_inner,
  output logic [NUM_FEAT-1:0]           last_inner,
  input  logic [ACCUM_SIZE-1:0]         accum_final,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [ACCUM_SIZE-1:0]         res_data,
  output logic                          busy
`ifdef SVM_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_jobs,
  output logic [31:0]                   perf_busy
`endif
);

  localparam int NW   = AW + 1;
  localparam int FW   = $clog2(NUM_FEAT) + 1;
  localparam int CW   = (NW > FW) ? NW : FW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;        // down-counter: remaining FETCH / WAIT cycles
  logic [NW-1:0] n_lat;      // clamped SV count of the running job
  logic [NW-1:0] n_clamp;
  logic          accept;
  logic          rd_vld_d;   // sv_rdata carries valid data this cycle

  assign req_ready  = (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign accum_seed = '0;

  always_comb begin
    n_clamp = cfg_num_sv;
    if (cfg_num_sv < NW'(2))
      n_clamp = NW'(2);
    else if (cfg_num_sv > NW'(MAX_SV))
      n_clamp = NW'(MAX_SV);
  end

  // ---------------------------------------------------------------------------
  // Job FSM. The counter is loaded with N-1 on accept and with NUM_FEAT-1 on
  // entering WAIT; each state ends on its terminal count of zero.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      n_lat       <= '0;
      curr_vector <= '0;
      sv_rd_en    <= 1'b0;
      sv_addr     <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            curr_vector <= req_vector;
            n_lat       <= n_clamp;
            cnt         <= CW'(n_clamp - NW'(1));
            sv_rd_en    <= 1'b1;
            sv_addr     <= '0;
            busy        <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: begin
          if (cnt == '0) begin
            sv_rd_en <= 1'b0;
            sv_addr  <= '0;
            cnt      <= CW'(NUM_FEAT - 1);
            state    <= WAIT;
          end else begin
            sv_addr <= sv_addr + AW'(1);
            cnt     <= cnt - CW'(1);
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            res_data  <= accum_final;
            res_valid <= 1'b1;
            state     <= RESULT;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Strobe pipeline. Stage 0 strobes line up with the read data (one cycle
  // after the read); every further stage is one more cycle late.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_d    <= 1'b0;
      start_inner <= '0;
      last_inner  <= '0;
    end else begin
      rd_vld_d       <= sv_rd_en;
      start_inner[0] <= sv_rd_en && (sv_addr == '0);
      last_inner[0]  <= sv_rd_en && ({1'b0, sv_addr} == (n_lat - NW'(1)));
      for (int k = 1; k < NUM_FEAT; k++) begin
        start_inner[k] <= start_inner[k-1];
        last_inner[k]  <= last_inner[k-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // SV lane skew. Lane 0 is the gated read data itself; lane k passes through
  // a k-deep register chain. Gating with rd_vld_d keeps lanes at zero outside
  // their active cycles, and the chains carry those zeros along.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_FEAT; k++) begin : g_lane
    if (k == 0) begin : g_direct
      assign sv_lane[0 +: DATA_SIZE] = rd_vld_d ? sv_rdata[0 +: DATA_SIZE] : '0;
    end else begin : g_skew
      logic [DATA_SIZE-1:0] skew [k];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < k; i++)
            skew[i] <= '0;
        end else begin
          skew[0] <= rd_vld_d ? sv_rdata[k*DATA_SIZE +: DATA_SIZE] : '0;
          for (int i = 1; i < k; i++)
            skew[i] <= skew[i-1];
        end
      end

      assign sv_lane[k*DATA_SIZE +: DATA_SIZE] = skew[k-1];
    end
  end

`ifdef SVM_CTRL_PERF_CNT_EN
  // The accept cycle counts as the first busy cycle of a job, so a job with
  // res_ready already high contributes N+NUM_FEAT+2 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_jobs <= '0;
      perf_busy <= '0;
    end else begin
      if (res_valid && res_ready)
        perf_jobs <= perf_jobs + 32'd1;
      if (busy || accept)
        perf_busy <= perf_busy + 32'd1;
    end
  end
`else
  // No performance counters in this build.
`endif

endmodule
